seq_demux_4b_1to8: RTL
======================

# seq_demux_4b_1to8

Registered 1-to-8 demultiplexer for 4-bit values: it routes each accepted input transfer to one of eight output lanes, or to all eight, chosen by a select field. Each lane holds its value in a one-entry buffer with a valid/ready handshake toward its consumer. The block is the distribution end of the 4-bit, 8-lane datapath, complementing the 8-to-1 mux on the gathering side. A saturating transfer counter is provided for debug visibility.

## Interface
Parameters: none; widths and lane count are fixed by package constants.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in_val  input  1  input transfer valid
- in_rdy  output  1  block can accept the input this cycle
- in_data  input  4  input value
- in_sel  input  3  destination lane, 0..7; ignored when in_bcast=1
- in_bcast  input  1  write in_data to all eight lanes
- out_val  output  8  bit i = lane i holds valid data
- out_rdy  input  8  bit i = lane i consumer accepts this cycle
- out0 .. out7  output  4 each  lane data registers
- xfer_count  output  8  number of accepted input transfers, saturating at 255

## Operation
- Lane i state: full_i (drives out_val[i]) and data_i (drives out_i).
- Lane i can accept when (!full_i || out_rdy[i]).
- Unicast (in_bcast=0): in_rdy = lane in_sel can accept. The transfer fires when in_val && in_rdy.
- Broadcast (in_bcast=1): in_rdy = AND over all lanes of "can accept". The transfer fires only when all eight lanes can take it; no partial broadcast.
- Input fire: the target lane(s) load data_i <= in_data and set full_i <= 1.
- Output fire on lane i (out_val[i] && out_rdy[i]) with no load that cycle: full_i <= 0, and data_i is held.
- Output fire and load on the same lane in the same cycle: full_i stays 1 and data_i takes the new value. Throughput is one transfer per cycle per lane.
- Non-target lanes are unaffected by an input fire; they dequeue independently.
- xfer_count increments by 1 per input fire; a broadcast counts once. It holds at 255.
- in_data and in_sel are don't-care when in_val=0. in_rdy is still driven combinationally from in_sel, in_bcast and lane state.

## Timing
- Reset (reset=0, asynchronous) clears out_val to 0, out0..out7 to 0 and xfer_count to 0. It takes effect immediately, mid-transfer included, and the in-flight transfer is lost. Release is synchronous to clk.
- Latency: a value accepted at edge N appears on out_val/out_i after edge N, i.e. it is visible in cycle N+1.
- in_rdy depends combinationally on out_rdy (pass-through ready). out_val and out_i are register outputs only.
- Lane full and out_rdy[i]=0: in_rdy=0 for that target, and the lane holds its data and valid unchanged.
- All lanes empty: in_rdy=1 for any in_sel and for broadcast.

## Structure
- Package seq_demux_pkg holds the constants DATA_NBITS=4, NUM_LANES=8 and SEL_NBITS=3, plus the counter width XFER_CNT_NBITS=8.
- Sub-module demux_lane_buf holds one lane's one-entry buffer.
  - Ports: clk, reset, load, load_data, deq_rdy, full, data, can_accept.
  - The top level instantiates it eight times and adds the select decode, broadcast AND-reduce and counter.

## Test plan
- Reset: assert reset=0 mid-cycle with lane 3 full, then release -> out_val=8'h00, out0..out7=0 and xfer_count=0 immediately; in_rdy=1 for any in_sel.
- Unicast routing: for sel=0..7, send in_data=sel+1 with out_rdy=0 -> after 8 transfers out_val=8'hFF, out_i=i+1 and xfer_count=8.
- Backpressure: lane 5 full, out_rdy[5]=0, in_val=1, in_sel=5, in_data=9 -> in_rdy=0 and out5 unchanged. Then raise out_rdy[5]=1 -> in_rdy=1, out5=9 next cycle and out_val[5] stays 1.
- Broadcast blocking: lane 2 full with out_rdy[2]=0, in_bcast=1, in_data=4'hA -> in_rdy=0 and no lane changes. Then set out_rdy[2]=1 -> all lanes hold 4'hA next cycle and xfer_count increments by exactly 1.
- Streaming: in_sel=1 every cycle with data 0,1,2,... and out_rdy[1]=1 -> one value per cycle on out1, each one cycle after acceptance; out_val[1]=1 throughout.
- Counter saturation: 300 accepted transfers -> xfer_count=255, and routing is unaffected.

Source files
------------

// File: rtl/seq_demux_pkg.sv
// seq_demux_pkg: shared constants and helpers for the 4-bit, 8-lane distribution datapath.
//   DATA_NBITS     - width of one lane value
//   NUM_LANES      - number of output lanes
//   SEL_NBITS      - width of the lane select field
//   XFER_CNT_NBITS - width of the saturating transfer counter
package seq_demux_pkg;

  localparam int unsigned DATA_NBITS     = 4;
  localparam int unsigned NUM_LANES      = 8;
  localparam int unsigned SEL_NBITS      = 3;
  localparam int unsigned XFER_CNT_NBITS = 8;

  typedef logic [DATA_NBITS-1:0]     lane_data_t;
  typedef logic [XFER_CNT_NBITS-1:0] xfer_cnt_t;

  // Increment that sticks at the all-ones value.
  function automatic xfer_cnt_t sat_inc(input xfer_cnt_t value);
    return (&value) ? value : value + xfer_cnt_t'(1);
  endfunction

endpackage

// File: rtl/demux_lane_buf.sv
// demux_lane_buf: one-entry output buffer for a single demux lane.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   load       - write load_data into the buffer this cycle (only asserted when can_accept)
//   load_data  - value to store
//   deq_rdy    - consumer accepts the held value this cycle
//   full       - buffer holds valid data (lane valid)
//   data       - held value
//   can_accept - buffer is empty or is being drained this cycle
module demux_lane_buf
  import seq_demux_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  lane_data_t load_data,
  input  logic       deq_rdy,
  output logic       full,
  output lane_data_t data,
  output logic       can_accept
);

  logic       full_q, full_d;
  lane_data_t data_q, data_d;

  // Pass-through ready: a full buffer still accepts when it drains in the same cycle.
  assign can_accept = !full_q || deq_rdy;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      // A simultaneous dequeue is covered too: the slot stays occupied by the new value.
      full_d = 1'b1;
      data_d = load_data;
    end else if (full_q && deq_rdy) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/seq_demux_4b_1to8.sv
// seq_demux_4b_1to8: registered 1-to-8 demultiplexer for 4-bit values with per-lane
// one-entry buffers, unicast or broadcast routing and a saturating transfer counter.
// Ports:
//   clk, reset          - clock (rising edge), asynchronous active-low reset
//   in_val/in_rdy       - input handshake; in_rdy is combinational from lane state and out_rdy
//   in_data             - input value
//   in_sel              - destination lane (ignored when in_bcast=1)
//   in_bcast            - write in_data to all lanes; fires only when every lane can accept
//   out_val/out_rdy     - per-lane output handshake (bit i = lane i)
//   out0..out7          - lane data registers
//   xfer_count          - accepted input transfers, saturating at 255
module seq_demux_4b_1to8
  import seq_demux_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [DATA_NBITS-1:0] in_data,
  input  logic [SEL_NBITS-1:0] in_sel,
  input  logic                 in_bcast,
  output logic [NUM_LANES-1:0] out_val,
  input  logic [NUM_LANES-1:0] out_rdy,
  output logic [DATA_NBITS-1:0] out0,
  output logic [DATA_NBITS-1:0] out1,
  output logic [DATA_NBITS-1:0] out2,
  output logic [DATA_NBITS-1:0] out3,
  output logic [DATA_NBITS-1:0] out4,
  output logic [DATA_NBITS-1:0] out5,
  output logic [DATA_NBITS-1:0] out6,
  output logic [DATA_NBITS-1:0] out7,
  output logic [XFER_CNT_NBITS-1:0] xfer_count
);

  logic [NUM_LANES-1:0] lane_can_accept;
  logic [NUM_LANES-1:0] lane_full;
  logic [NUM_LANES-1:0] lane_load;
  lane_data_t           lane_data [NUM_LANES];
  logic                 in_fire;
  xfer_cnt_t            xfer_count_q;

  // Broadcast is all-or-nothing, so it needs every lane ready at once.
  assign in_rdy  = in_bcast ? (&lane_can_accept) : lane_can_accept[in_sel];
  assign in_fire = in_val && in_rdy;

  always_comb begin
    lane_load = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_load[i] = in_fire && (in_bcast || (in_sel == SEL_NBITS'(i)));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_lane_buf u_lane_buf (
      .clk        (clk),
      .reset      (reset),
      .load       (lane_load[g]),
      .load_data  (in_data),
      .deq_rdy    (out_rdy[g]),
      .full       (lane_full[g]),
      .data       (lane_data[g]),
      .can_accept (lane_can_accept[g])
    );
  end

  // A broadcast counts as a single transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_count_q <= '0;
    end else if (in_fire) begin
      xfer_count_q <= sat_inc(xfer_count_q);
    end
  end

  assign out_val    = lane_full;
  assign xfer_count = xfer_count_q;
  assign out0       = lane_data[0];
  assign out1       = lane_data[1];
  assign out2       = lane_data[2];
  assign out3       = lane_data[3];
  assign out4       = lane_data[4];
  assign out5       = lane_data[5];
  assign out6       = lane_data[6];
  assign out7       = lane_data[7];

endmodule
